restoration_sequencer: RTL and testbench

Multi-shot controller for the restoration propagation-delay measurement path.
- On `start`, it fires NUM_SHOTS pulser trigger requests and collects each Pulse_Propagation_Counter result.
- It averages the results and reports average, status and error.
- It sits between the host register bank and the restoration measurement block. It owns Pulser_Trigger_Request and consumes Pulse_Measurement_Done, Pulse_Propagation_Counter and Pulser_IC_Error.

---
 rtl/restoration_sequencer.sv | 167 ++++++++++++++++
 tb/tb_restoration_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/restoration_sequencer.sv
// Multi-shot propagation-delay sequencer: fires NUM_SHOTS pulser triggers, averages the measured counts.
// Optional per-shot min/max tracking is built only when RESTORATION_MINMAX_EN is defined.
module restoration_sequencer #(
  parameter int unsigned SHOT_LOG2      = 2,
  parameter int unsigned TRIG_WIDTH     = 8,
  parameter int unsigned GAP_CYCLES     = 64,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        Pulse_Measurement_Done,
  input  logic [15:0] Pulse_Propagation_Counter,
  input  logic        Pulser_IC_Error,
  output logic        Pulser_Trigger_Request,
  output logic        busy,
  output logic        done,
  output logic        error_timeout,
  output logic        error_ic,
  output logic [4:0]  shot_index,
  output logic [15:0] result_avg,
  output logic [15:0] result_min,
  output logic [15:0] result_max
);

  // state  | meaning
  // IDLE   | waiting for start
  // TRIG   | trigger request high for TRIG_WIDTH cycles
  // WAIT   | trigger low, waiting for a done rising edge or timeout
  // GAP    | idle spacing before the next shot's trigger
  // FINISH | one-cycle done strobe, results committed on success
  typedef enum logic [2:0] {IDLE, TRIG, WAIT, GAP, FINISH} state_t;

  localparam int unsigned ACC_W       = 16 + SHOT_LOG2;
  localparam logic [4:0]  NUM_SHOTS_L = 5'(1 << SHOT_LOG2);

  state_t             state, state_nxt;
  logic               done_q;
  logic [ACC_W-1:0]   acc, acc_sum;
  logic [15:0]        trig_cnt, gap_cnt, tmo_cnt;
  logic [4:0]         shot_nxt;
  logic               done_edge, tmo_hit, ic_abort, tmo_abort, shot_ok, last_ok;
  logic               enter_trig, enter_gap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_edge = Pulse_Measurement_Done & ~done_q;
    acc_sum   = acc + ACC_W'(Pulse_Propagation_Counter);
    shot_nxt  = shot_index + 5'd1;
    tmo_hit   = (tmo_cnt == 16'd0);
    ic_abort  = Pulser_IC_Error && (state inside {TRIG, WAIT, GAP});
    shot_ok   = (state == WAIT) && !ic_abort && done_edge;
    last_ok   = shot_ok && (shot_nxt == NUM_SHOTS_L);
    tmo_abort = !ic_abort && tmo_hit &&
                ((state == TRIG) || ((state == WAIT) && !done_edge));
    unique case (state)
      IDLE:    if (start) state_nxt = TRIG;
      TRIG: begin
        if (ic_abort || tmo_abort)  state_nxt = FINISH;
        else if (trig_cnt == 16'd0) state_nxt = WAIT;
      end
      WAIT: begin
        if (ic_abort || tmo_abort) state_nxt = FINISH;
        else if (shot_ok)          state_nxt = last_ok ? FINISH : GAP;
      end
      GAP: begin
        if (ic_abort)              state_nxt = FINISH;
        else if (gap_cnt == 16'd0) state_nxt = TRIG;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    enter_trig = (state_nxt == TRIG) && (state != TRIG);
    enter_gap  = (state_nxt == GAP) && (state != GAP);
  end

  // Output flags are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q                 <= 1'b0;
      Pulser_Trigger_Request <= 1'b0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      error_timeout          <= 1'b0;
      error_ic               <= 1'b0;
      shot_index             <= 5'd0;
      result_avg             <= 16'd0;
      acc                    <= '0;
      trig_cnt               <= 16'd0;
      gap_cnt                <= 16'd0;
      tmo_cnt                <= 16'd0;
    end else begin
      done_q                 <= Pulse_Measurement_Done;
      Pulser_Trigger_Request <= (state_nxt == TRIG);
      busy                   <= (state_nxt != IDLE);
      done                   <= (state_nxt == FINISH);

      if ((state == IDLE) && start) begin
        error_timeout <= 1'b0;
        error_ic      <= 1'b0;
        shot_index    <= 5'd0;
        acc           <= '0;
      end

      if (enter_trig) begin
        trig_cnt <= 16'(TRIG_WIDTH - 1);
        tmo_cnt  <= TIMEOUT_CYCLES - 16'd1;
      end else begin
        if (trig_cnt != 16'd0) trig_cnt <= trig_cnt - 16'd1;
        if (((state == TRIG) || (state == WAIT)) && (tmo_cnt != 16'd0))
          tmo_cnt <= tmo_cnt - 16'd1;
      end

      if (enter_gap)               gap_cnt <= 16'(GAP_CYCLES - 1);
      else if (gap_cnt != 16'd0)   gap_cnt <= gap_cnt - 16'd1;

      if (ic_abort)  error_ic      <= 1'b1;
      if (tmo_abort) error_timeout <= 1'b1;

      if (shot_ok) begin
        acc        <= acc_sum;
        shot_index <= shot_nxt;
      end
      // Commit on the edge entering FINISH so results are valid alongside done.
      if (last_ok) result_avg <= 16'(acc_sum >> SHOT_LOG2);
    end
  end

`ifdef RESTORATION_MINMAX_EN
  logic [15:0] run_min, run_max, min_nxt, max_nxt;

  always_comb begin
    min_nxt = (Pulse_Propagation_Counter < run_min) ? Pulse_Propagation_Counter : run_min;
    max_nxt = (Pulse_Propagation_Counter > run_max) ? Pulse_Propagation_Counter : run_max;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_min    <= 16'hFFFF;
      run_max    <= 16'h0000;
      result_min <= 16'h0000;
      result_max <= 16'h0000;
    end else begin
      if ((state == IDLE) && start) begin
        run_min <= 16'hFFFF;
        run_max <= 16'h0000;
      end else if (shot_ok) begin
        run_min <= min_nxt;
        run_max <= max_nxt;
      end
      if (last_ok) begin
        result_min <= min_nxt;
        result_max <= max_nxt;
      end
    end
  end
`else
  assign result_min = 16'h0000;
  assign result_max = 16'h0000;
`endif

endmodule

// File: tb/tb_restoration_sequencer.sv
// Directed bench for restoration_sequencer: table of whole sequences plus hand-written reset/IC corner cases.
// Expected min/max depend on whether RESTORATION_MINMAX_EN is defined for the build.
module tb_restoration_sequencer;
  localparam int GAP = 64;
  localparam int TW  = 8;
  localparam int TMO = 200;
`ifdef RESTORATION_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk, reset, start, meas_done, m_ic, t_ic, ic_err, trig;
  logic        busy, done, error_timeout, error_ic;
  logic [15:0] meas_val, result_avg, result_min, result_max;
  logic [4:0]  shot_index;

  assign ic_err = m_ic | t_ic;

  restoration_sequencer #(
    .SHOT_LOG2(2), .TRIG_WIDTH(TW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(16'(TMO))
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .Pulse_Measurement_Done(meas_done), .Pulse_Propagation_Counter(meas_val),
    .Pulser_IC_Error(ic_err), .Pulser_Trigger_Request(trig),
    .busy(busy), .done(done), .error_timeout(error_timeout), .error_ic(error_ic),
    .shot_index(shot_index), .result_avg(result_avg),
    .result_min(result_min), .result_max(result_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Measurement-block model controls, written only by the test process.
  logic [15:0] m_vals [4];
  bit          m_respond;
  int          m_ic_shot;
  int          m_scn;

  // Measurement model: drops the stale done 3 cycles after trigger rise, answers 20 cycles after it.
  initial begin : model
    int  cnt, drop, idx, scn_seen;
    logic trig_last;
    meas_done = 1'b0; meas_val = 16'd0; m_ic = 1'b0;
    cnt = -1; drop = -1; idx = 0; scn_seen = 0; trig_last = 1'b0;
    forever begin
      @(negedge clk);
      m_ic = 1'b0;
      if (m_scn != scn_seen) begin scn_seen = m_scn; idx = 0; end
      if (trig && !trig_last) begin drop = 3; cnt = 20; end
      trig_last = trig;
      if (drop == 0) meas_done = 1'b0;
      if (drop >= 0) drop--;
      if (cnt == 0 && m_respond) begin
        meas_val  = m_vals[idx % 4];
        meas_done = 1'b1;
        if (idx == m_ic_shot) m_ic = 1'b1;
        idx++;
      end
      if (cnt >= 0) cnt--;
    end
  end

  // Event log in cycle numbers, sampled 1 time unit after each rising edge.
  int cyc;
  int tr_rise[$], tr_fall[$], md_rise[$], dn_cyc[$];
  initial begin : mon
    logic tp, mp;
    cyc = 0; tp = 1'b0; mp = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (trig && !tp)      tr_rise.push_back(cyc);
      if (!trig && tp)      tr_fall.push_back(cyc);
      if (meas_done && !mp) md_rise.push_back(cyc);
      if (done)             dn_cyc.push_back(cyc);
      tp = trig; mp = meas_done;
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [15:0] v0, v1, v2, v3;
    bit          respond;
    int          ic_shot;
    logic [15:0] avg, mn, mx;
    logic [4:0]  shot;
    bit          eto, eic;
    int          ntrig;
  } vec_t;

  task automatic chk_zero(input string tag);
    chk({tag, "_trig"},  32'(trig), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_eto"},   32'(error_timeout), 0);
    chk({tag, "_eic"},   32'(error_ic), 0);
    chk({tag, "_shot"},  32'(shot_index), 0);
    chk({tag, "_avg"},   32'(result_avg), 0);
    chk({tag, "_min"},   32'(result_min), 0);
    chk({tag, "_max"},   32'(result_max), 0);
  endtask

  task automatic run_row(input vec_t r, input string tag);
    int rb, fb, mb, db;
    bit got;
    m_vals[0] = r.v0; m_vals[1] = r.v1; m_vals[2] = r.v2; m_vals[3] = r.v3;
    m_respond = r.respond; m_ic_shot = r.ic_shot; m_scn++;
    @(negedge clk);
    rb = tr_rise.size(); fb = tr_fall.size(); mb = md_rise.size(); db = dn_cyc.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done) begin got = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 32'(got), 1);
    chk({tag, "_avg"},  32'(result_avg), 32'(r.avg));
    chk({tag, "_min"},  32'(result_min), MM ? 32'(r.mn) : 32'd0);
    chk({tag, "_max"},  32'(result_max), MM ? 32'(r.mx) : 32'd0);
    chk({tag, "_shot"}, 32'(shot_index), 32'(r.shot));
    chk({tag, "_eto"},  32'(error_timeout), 32'(r.eto));
    chk({tag, "_eic"},  32'(error_ic), 32'(r.eic));
    repeat (3) @(negedge clk);
    chk({tag, "_busy_end"},    32'(busy), 0);
    chk({tag, "_done_pulses"}, dn_cyc.size() - db, 1);
    chk({tag, "_ntrig"},       tr_rise.size() - rb, r.ntrig);
    for (int i = 0; i < r.ntrig; i++)
      chk($sformatf("%s_width%0d", tag, i), tr_fall[fb + i] - tr_rise[rb + i], TW);
    for (int i = 0; i < r.ntrig - 1; i++)
      chk($sformatf("%s_gap%0d", tag, i), tr_rise[rb + i + 1] - md_rise[mb + i], GAP);
    if (r.eto) chk({tag, "_tmo_latency"}, dn_cyc[db] - tr_rise[rb], TMO);
  endtask

  initial begin : test
    vec_t tbl[6];
    int rb, fb, mb;
    bit got;
    tbl[0] = '{16'd100, 16'd104, 16'd96, 16'd100, 1'b1, -1, 16'd100, 16'd96, 16'd104, 5'd4, 1'b0, 1'b0, 4};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, -1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'd4, 1'b0, 1'b0, 4};
    tbl[2] = '{16'd1, 16'd2, 16'd3, 16'd4, 1'b1, -1, 16'd2, 16'd1, 16'd4, 5'd4, 1'b0, 1'b0, 4};
    tbl[3] = '{16'd0, 16'd0, 16'd0, 16'd0, 1'b0, -1, 16'd2, 16'd1, 16'd4, 5'd0, 1'b1, 1'b0, 1};
    tbl[4] = '{16'd10, 16'd20, 16'd30, 16'd40, 1'b1, 1, 16'd2, 16'd1, 16'd4, 5'd1, 1'b0, 1'b1, 2};
    tbl[5] = '{16'd0, 16'd0, 16'd0, 16'd7, 1'b1, -1, 16'd1, 16'd0, 16'd7, 5'd4, 1'b0, 1'b0, 4};

    reset = 1'b1; start = 1'b0; t_ic = 1'b0;
    m_respond = 1'b1; m_ic_shot = -1; m_scn = 0;
    m_vals[0] = 16'd0; m_vals[1] = 16'd0; m_vals[2] = 16'd0; m_vals[3] = 16'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_row(tbl[i], $sformatf("row%0d", i));

    // Second start during GAP is ignored; reset mid-WAIT clears everything.
    m_vals[0] = 16'd50; m_vals[1] = 16'd50; m_vals[2] = 16'd50; m_vals[3] = 16'd50;
    m_respond = 1'b1; m_ic_shot = -1; m_scn++;
    @(negedge clk);
    rb = tr_rise.size(); fb = tr_fall.size(); mb = md_rise.size();
    start = 1'b1; @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (md_rise.size() > mb) begin got = 1'b1; break; end
    end
    chk("rst_first_shot_seen", 32'(got), 1);
    repeat (10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tr_fall.size() >= fb + 2) begin got = 1'b1; break; end
    end
    chk("rst_second_trig_seen", 32'(got), 1);
    chk("rst_restart_ignored_shot", 32'(shot_index), 1);
    chk("rst_restart_ignored_gap", tr_rise[rb + 1] - md_rise[mb], GAP);
    chk("rst_busy_before", 32'(busy), 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_zero("rst_mid_wait");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run_row(tbl[0], "fresh");

    // IC error present in the start cycle: enter TRIG for one cycle, then abort.
    m_respond = 1'b1; m_ic_shot = -1; m_scn++;
    @(negedge clk);
    rb = tr_rise.size(); fb = tr_fall.size();
    start = 1'b1; t_ic = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("icstart_trig_high", 32'(trig), 1);
    @(negedge clk);
    t_ic = 1'b0;
    chk("icstart_trig_dropped", 32'(trig), 0);
    chk("icstart_done", 32'(done), 1);
    chk("icstart_eic", 32'(error_ic), 1);
    chk("icstart_eto", 32'(error_timeout), 0);
    chk("icstart_shot", 32'(shot_index), 0);
    chk("icstart_avg_kept", 32'(result_avg), 100);
    repeat (3) @(negedge clk);
    chk("icstart_width", tr_fall[fb] - tr_rise[rb], 1);
    chk("icstart_busy_end", 32'(busy), 0);

    // Reset while the trigger is high must drop it without waiting for a clock edge.
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("async_trig_high", 32'(trig), 1);
    #2 reset = 1'b1;
    #1 chk("async_trig_drop", 32'(trig), 0);
    chk("async_busy_drop", 32'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
